lsu_bus_initiator: RTL and testbench
====================================

# lsu_bus_initiator

Load/store initiator that drives the combined text/data memory bus on behalf of the core's memory stage. Accepts one byte, halfword or word request at a time and converts it into word-aligned bus beats with byte enables. Read data is realigned and sign- or zero-extended before it is returned. Accesses that cross a word boundary are split into two beats, or rejected when splitting is compiled out.

## Interface
Parameters: none; address and data are fixed at 32 bits.

Ports (one clock; reset is asynchronous and active-low):
- clock  in  1  core clock; the bus memories sample on its rising edge
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; a request is accepted on an edge with req_valid && req_ready
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- req_unsigned  in  1  loads: zero-extend if 1, sign-extend if 0
- req_address  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_error  out  1  qualified by resp_valid; illegal size, or crossing access with split disabled
- bus_address  out  32  word-aligned; bits [1:0] always 0
- bus_write_data  out  32  lane-aligned store data
- bus_byte_enable  out  4  active lanes for the beat
- bus_read_enable  out  1  read strobe
- bus_write_enable  out  1  write strobe
- bus_read_data  in  32  valid the cycle after the address is presented; the address must still be held

## Operation
- The request is latched at acceptance. All bus outputs are registered from the latched request.
- off = addr[1:0]; nbytes = 1, 2 or 4. The access is "crossing" when off + nbytes > 4.
- Lane mask:
  - mask8 = base << off, where base is 0001, 0011 or 1111 (8-bit result).
  - beat0 enables = mask8[3:0]; beat1 enables = mask8[7:4].
- Store data:
  - wd64 = {32'b0, wdata} << (8*off).
  - beat0 data = wd64[31:0]; beat1 data = wd64[63:32].
- Beat addresses:
  - beat0 = {addr[31:2], 2'b00}.
  - beat1 = beat0 + 4, modulo 2^32; 0xFFFFFFFC wraps to 0x00000000.
- Load assembly:
  - rd64 = {beat1_data, beat0_data} >> (8*off); beat1_data = 0 when not split.
  - Take the low nbytes, then extend per req_unsigned.
- A non-crossing misaligned halfword (off = 1) is a single beat with enables 0110.
- States: IDLE, ISSUE, CAPTURE, RESP.
  - IDLE: req_ready = 1, all strobes 0.
    - Illegal size, or crossing with split disabled: go to RESP with error = 1 and no bus activity.
    - Otherwise go to ISSUE with beat = 0.
  - ISSUE: drive the beat's address, enables and strobe.
    - Write: strobe for exactly one cycle. Go to ISSUE (beat 1) if crossing and beat = 0, else RESP.
    - Read: go to CAPTURE.
  - CAPTURE: address, enables and bus_read_enable held unchanged; bus_read_data is latched at the end of the cycle.
    - Crossing and beat = 0: go to ISSUE with beat = 1.
    - Otherwise: go to RESP.
  - RESP: resp_valid = 1 for one cycle, then IDLE.
- A write beat never asserts bus_read_enable, and a read beat never asserts bus_write_enable.

## Timing
Latency is counted from the acceptance edge to the resp_valid cycle:
- Aligned or non-crossing write: 2 cycles.
- Non-crossing read: 3 cycles.
- Crossing write: 3 cycles.
- Crossing read: 5 cycles.
- Error: 1 cycle.

Throughput:
- Back-to-back requests are possible: req_ready rises the cycle after RESP, giving one idle cycle between responses.
- No request is accepted while busy.

Reset values:
- State IDLE; req_ready = 1.
- resp_valid, resp_error and resp_rdata = 0.
- bus_address = 0, bus_write_data = 0, bus_byte_enable = 0, both strobes = 0.

Reset mid-operation:
- Returns to IDLE immediately; no response is produced.
- A crossing store may leave beat 0 committed. This is a documented limitation.

## Configuration
- MISALIGNED_SPLIT_EN defined: crossing accesses are split into two beats as described above.
- MISALIGNED_SPLIT_EN undefined:
  - Crossing accesses produce resp_error = 1 after 1 cycle, with no strobes.
  - The beat-1 logic and the upper 32 bits of rd64 are removed.
  - Non-crossing accesses behave identically in both builds.

## Structure
- lsu_pkg holds:
  - typedef enum for size: LSU_BYTE, LSU_HALF, LSU_WORD.
  - typedef enum for state: IDLE, ISSUE, CAPTURE, RESP.
  - localparam for the size-to-base-mask table.
- Sub-module lsu_lane_align: combinational mask/shift for stores and shift/extend for loads. It is instantiated once, and the FSM stays in the top module.

## Test plan
- Aligned word store then load:
  - Store 0xDEADBEEF at DATA_BEGIN+0x10 gives one beat, enables 1111, latency 2.
  - Loading the same address returns 0xDEADBEEF with resp_valid 3 cycles after acceptance.
- Byte lanes:
  - Storing byte 0x80 at DATA_BEGIN+0x13 gives enables 1000 and bus_write_data 0x80000000.
  - A signed byte load returns 0xFFFFFF80; an unsigned byte load returns 0x00000080.
- Non-crossing halfword:
  - Storing half 0xA5C3 at DATA_BEGIN+0x21 gives one beat, enables 0110, data 0x00A5C300.
  - A signed load returns 0xFFFFA5C3.
- Crossing word, split build:
  - Store 0x11223344 at DATA_BEGIN+0x32 gives two beats: 0x...30 with enables 1100 and data 0x33440000, then 0x...34 with enables 0011 and data 0x00001122.
  - The word load returns 0x11223344 at latency 5.
- Error paths:
  - Size 3 gives resp_error = 1 and no strobes at latency 1.
  - With MISALIGNED_SPLIT_EN undefined, a crossing word load gives the same error response.
- Reset during the CAPTURE cycle of a read: drop reset_n, then check that all outputs are 0 while reset is low, no resp_valid is produced, and req_ready = 1 after release.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and lane tables for the load/store bus initiator.
// No logic of its own; no latency or backpressure.
// Helpers map a request size to its base lane mask and byte count.
package lsu_pkg;

    typedef enum logic [1:0] {
        LSU_BYTE = 2'd0,
        LSU_HALF = 2'd1,
        LSU_WORD = 2'd2
    } lsu_size_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } lsu_state_e;

    localparam logic [3:0] LSU_BASE_MASK [3] = '{4'b0001, 4'b0011, 4'b1111};

    function automatic logic size_legal(input logic [1:0] size);
        return size != 2'd3;
    endfunction

    function automatic logic [3:0] base_mask(input logic [1:0] size);
        case (size)
            LSU_BYTE: return LSU_BASE_MASK[0];
            LSU_HALF: return LSU_BASE_MASK[1];
            LSU_WORD: return LSU_BASE_MASK[2];
            default:  return 4'b0000;
        endcase
    endfunction

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            LSU_BYTE: return 3'd1;
            LSU_HALF: return 3'd2;
            default:  return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/lsu_bus_initiator_if.sv
// Request/response and memory-bus signals of the load/store initiator.
// master = the initiator itself; slave = core side plus bus memories.
// Request side uses valid/ready; the bus side has no backpressure.
interface lsu_bus_initiator_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_address;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] bus_address;
    logic [31:0] bus_write_data;
    logic [3:0]  bus_byte_enable;
    logic        bus_read_enable;
    logic        bus_write_enable;
    logic [31:0] bus_read_data;

    modport master (
        input  req_valid, req_write, req_size, req_unsigned, req_address, req_wdata,
        input  bus_read_data,
        output req_ready, resp_valid, resp_rdata, resp_error,
        output bus_address, bus_write_data, bus_byte_enable, bus_read_enable, bus_write_enable
    );

    modport slave (
        output req_valid, req_write, req_size, req_unsigned, req_address, req_wdata,
        output bus_read_data,
        input  req_ready, resp_valid, resp_rdata, resp_error,
        input  bus_address, bus_write_data, bus_byte_enable, bus_read_enable, bus_write_enable
    );
endinterface

// File: rtl/lsu_lane_align.sv
// Lane mask / store shift and load shift / extend (MISALIGNED_SPLIT_EN adds the upper beat).
// Purely combinational, zero latency.
// No backpressure.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic        zero_ext,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata_lo,
`ifdef MISALIGNED_SPLIT_EN
    input  logic [31:0] rdata_hi,
    output logic [3:0]  be_hi,
    output logic [31:0] wdata_hi,
`endif
    output logic [3:0]  be_lo,
    output logic [31:0] wdata_lo,
    output logic [31:0] load_data
);

    logic [31:0] rd_shift;

`ifdef MISALIGNED_SPLIT_EN
    logic [7:0]  mask8;
    logic [63:0] wd64;

    assign mask8    = {4'b0000, base_mask(size)} << off;
    assign wd64     = {32'b0, wdata} << {off, 3'b000};
    assign be_lo    = mask8[3:0];
    assign be_hi    = mask8[7:4];
    assign wdata_lo = wd64[31:0];
    assign wdata_hi = wd64[63:32];
    assign rd_shift = 32'({rdata_hi, rdata_lo} >> {off, 3'b000});
`else
    assign be_lo    = base_mask(size) << off;
    assign wdata_lo = wdata << {off, 3'b000};
    assign rd_shift = rdata_lo >> {off, 3'b000};
`endif

    always_comb begin
        load_data = rd_shift;
        case (size)
            LSU_BYTE: load_data = zero_ext ? {24'b0, rd_shift[7:0]}
                                           : {{24{rd_shift[7]}}, rd_shift[7:0]};
            LSU_HALF: load_data = zero_ext ? {16'b0, rd_shift[15:0]}
                                           : {{16{rd_shift[15]}}, rd_shift[15:0]};
            default:  load_data = rd_shift;
        endcase
    end

endmodule

// File: rtl/lsu_bus_initiator.sv
// Load/store initiator: one request -> word-aligned bus beats (MISALIGNED_SPLIT_EN splits crossings).
// Latency: error 1, store 2 (crossing 3), load 3 (crossing 5) cycles from acceptance.
// req_ready only in IDLE; one request in flight, bus itself never stalls.
module lsu_bus_initiator
    import lsu_pkg::*;
(
    input  logic               clock,
    input  logic               reset_n,
    lsu_bus_initiator_if.master lsu
);

    lsu_state_e  state, state_n;
    logic        lat_write, lat_unsigned;
    logic [1:0]  lat_size;
    logic [31:0] lat_address, lat_wdata;
    logic        err_n;

    logic        src_write, src_unsigned;
    logic [1:0]  src_size;
    logic [31:0] src_address, src_wdata;
    logic        crossing;
    logic [31:0] beat0_address;

    logic [3:0]  be_lo;
    logic [31:0] wdata_lo, rdata_lo, load_data;

    logic [31:0] bus_address_n, bus_write_data_n;
    logic [3:0]  bus_byte_enable_n;
    logic        bus_read_enable_n, bus_write_enable_n;

`ifdef MISALIGNED_SPLIT_EN
    logic        beat, beat_n;
    logic [31:0] beat0_data, rdata_hi, wdata_hi;
    logic [3:0]  be_hi;
`endif

    assign lsu.req_ready = (state == IDLE);

    // Bus outputs are registered, so the first beat is built from the live request in IDLE.
    assign src_write     = (state == IDLE) ? lsu.req_write    : lat_write;
    assign src_unsigned  = (state == IDLE) ? lsu.req_unsigned : lat_unsigned;
    assign src_size      = (state == IDLE) ? lsu.req_size     : lat_size;
    assign src_address   = (state == IDLE) ? lsu.req_address  : lat_address;
    assign src_wdata     = (state == IDLE) ? lsu.req_wdata    : lat_wdata;

    assign crossing      = ({1'b0, src_address[1:0]} + size_bytes(src_size)) > 3'd4;
    assign beat0_address = {src_address[31:2], 2'b00};

`ifdef MISALIGNED_SPLIT_EN
    assign rdata_lo = beat ? beat0_data : lsu.bus_read_data;
    assign rdata_hi = beat ? lsu.bus_read_data : 32'b0;
`else
    assign rdata_lo = lsu.bus_read_data;
`endif

    lsu_lane_align u_align (
        .size      (src_size),
        .off       (src_address[1:0]),
        .zero_ext  (src_unsigned),
        .wdata     (src_wdata),
        .rdata_lo  (rdata_lo),
`ifdef MISALIGNED_SPLIT_EN
        .rdata_hi  (rdata_hi),
        .be_hi     (be_hi),
        .wdata_hi  (wdata_hi),
`endif
        .be_lo     (be_lo),
        .wdata_lo  (wdata_lo),
        .load_data (load_data)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        err_n   = 1'b0;
`ifdef MISALIGNED_SPLIT_EN
        beat_n  = beat;
`endif
        case (state)
            IDLE: begin
                if (lsu.req_valid) begin
                    if (!size_legal(lsu.req_size)) begin
                        state_n = RESP;
                        err_n   = 1'b1;
                    end
`ifndef MISALIGNED_SPLIT_EN
                    else if (crossing) begin
                        state_n = RESP;
                        err_n   = 1'b1;
                    end
`endif
                    else begin
                        state_n = ISSUE;
`ifdef MISALIGNED_SPLIT_EN
                        beat_n  = 1'b0;
`endif
                    end
                end
            end
            ISSUE: begin
                if (lat_write) begin
`ifdef MISALIGNED_SPLIT_EN
                    if (crossing && !beat) beat_n = 1'b1;
                    else
`endif
                    state_n = RESP;
                end else begin
                    state_n = CAPTURE;
                end
            end
            CAPTURE: begin
`ifdef MISALIGNED_SPLIT_EN
                if (crossing && !beat) begin
                    state_n = ISSUE;
                    beat_n  = 1'b1;
                end else
`endif
                state_n = RESP;
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        bus_address_n      = '0;
        bus_write_data_n   = '0;
        bus_byte_enable_n  = '0;
        bus_read_enable_n  = 1'b0;
        bus_write_enable_n = 1'b0;
        if (state_n == ISSUE) begin
            bus_address_n     = beat0_address;
            bus_byte_enable_n = be_lo;
            bus_write_data_n  = src_write ? wdata_lo : '0;
`ifdef MISALIGNED_SPLIT_EN
            if (beat_n) begin
                bus_address_n     = beat0_address + 32'd4;
                bus_byte_enable_n = be_hi;
                bus_write_data_n  = src_write ? wdata_hi : '0;
            end
`endif
            bus_write_enable_n = src_write;
            bus_read_enable_n  = !src_write;
        end else if (state_n == CAPTURE) begin
            // The memory returns data a cycle later and needs the address held.
            bus_address_n      = lsu.bus_address;
            bus_write_data_n   = lsu.bus_write_data;
            bus_byte_enable_n  = lsu.bus_byte_enable;
            bus_read_enable_n  = lsu.bus_read_enable;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lat_write            <= 1'b0;
            lat_unsigned         <= 1'b0;
            lat_size             <= 2'd0;
            lat_address          <= '0;
            lat_wdata            <= '0;
            lsu.resp_valid       <= 1'b0;
            lsu.resp_error       <= 1'b0;
            lsu.resp_rdata       <= '0;
            lsu.bus_address      <= '0;
            lsu.bus_write_data   <= '0;
            lsu.bus_byte_enable  <= '0;
            lsu.bus_read_enable  <= 1'b0;
            lsu.bus_write_enable <= 1'b0;
`ifdef MISALIGNED_SPLIT_EN
            beat                 <= 1'b0;
            beat0_data           <= '0;
`endif
        end else begin
            if (lsu.req_valid && lsu.req_ready) begin
                lat_write    <= lsu.req_write;
                lat_unsigned <= lsu.req_unsigned;
                lat_size     <= lsu.req_size;
                lat_address  <= lsu.req_address;
                lat_wdata    <= lsu.req_wdata;
            end
            lsu.resp_valid       <= (state_n == RESP);
            lsu.resp_error       <= err_n;
            lsu.resp_rdata       <= (state == CAPTURE && state_n == RESP) ? load_data : '0;
            lsu.bus_address      <= bus_address_n;
            lsu.bus_write_data   <= bus_write_data_n;
            lsu.bus_byte_enable  <= bus_byte_enable_n;
            lsu.bus_read_enable  <= bus_read_enable_n;
            lsu.bus_write_enable <= bus_write_enable_n;
`ifdef MISALIGNED_SPLIT_EN
            beat                 <= beat_n;
            if (state == CAPTURE && !beat) beat0_data <= lsu.bus_read_data;
`endif
        end
    end

endmodule

// File: tb/tb_lsu_bus_initiator.sv
// Directed bench for lsu_bus_initiator with a byte-lane memory on the bus.
// Follows MISALIGNED_SPLIT_EN to pick the expected crossing behaviour.
module tb_lsu_bus_initiator;

    localparam logic [31:0] DATA_BEGIN = 32'h0000_1000;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    lsu_bus_initiator_if lsu ();

    lsu_bus_initiator dut (
        .clock   (clock),
        .reset_n (reset_n),
        .lsu     (lsu)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [64];
    int          wr_total = 0;
    int          rd_cycles = 0;
    int          resp_count = 0;
    logic [31:0] wlog_addr [64];
    logic [3:0]  wlog_be   [64];
    logic [31:0] wlog_dat  [64];

    int          w0, r0, rc, t_lat;
    logic        t_got, t_err;
    logic [31:0] t_rd;

    always @(posedge clock) begin
        if (lsu.bus_write_enable)
            for (int i = 0; i < 4; i++)
                if (lsu.bus_byte_enable[i])
                    mem[lsu.bus_address[7:2]][8*i +: 8] <= lsu.bus_write_data[8*i +: 8];
        if (lsu.bus_read_enable)
            lsu.bus_read_data <= mem[lsu.bus_address[7:2]];
    end

    always @(negedge clock) begin
        if (lsu.bus_write_enable && wr_total < 64) begin
            wlog_addr[wr_total] = lsu.bus_address;
            wlog_be[wr_total]   = lsu.bus_byte_enable;
            wlog_dat[wr_total]  = lsu.bus_write_data;
            wr_total++;
        end
        if (lsu.bus_read_enable) rd_cycles++;
        if (lsu.resp_valid) resp_count++;
    end

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic do_req(input logic wr, input logic [1:0] sz, input logic us,
                          input logic [31:0] a, input logic [31:0] wd);
        @(negedge clock);
        w0 = wr_total;
        r0 = rd_cycles;
        lsu.req_write    = wr;
        lsu.req_size     = sz;
        lsu.req_unsigned = us;
        lsu.req_address  = a;
        lsu.req_wdata    = wd;
        lsu.req_valid    = 1'b1;
        @(posedge clock);
        #1 lsu.req_valid = 1'b0;
        t_lat = 1;
        @(negedge clock);
        check("busy_ready", 32'(lsu.req_ready), 32'd0);
        while (!lsu.resp_valid && t_lat < 12) begin
            @(negedge clock);
            t_lat++;
        end
        t_got = lsu.resp_valid;
        t_rd  = lsu.resp_rdata;
        t_err = lsu.resp_error;
        check("resp_seen", 32'(t_got), 32'd1);
    endtask

    initial begin
        reset_n          = 1'b0;
        lsu.req_valid    = 1'b0;
        lsu.req_write    = 1'b0;
        lsu.req_size     = 2'd0;
        lsu.req_unsigned = 1'b0;
        lsu.req_address  = '0;
        lsu.req_wdata    = '0;
        repeat (2) @(negedge clock);
        check("rst_ready",   32'(lsu.req_ready), 32'd1);
        check("rst_rvalid",  32'(lsu.resp_valid), 32'd0);
        check("rst_rerror",  32'(lsu.resp_error), 32'd0);
        check("rst_rdata",   lsu.resp_rdata, 32'd0);
        check("rst_baddr",   lsu.bus_address, 32'd0);
        check("rst_bwdata",  lsu.bus_write_data, 32'd0);
        check("rst_be",      32'(lsu.bus_byte_enable), 32'd0);
        check("rst_strobes", 32'({lsu.bus_read_enable, lsu.bus_write_enable}), 32'd0);
        reset_n = 1'b1;

        // aligned word store / load
        do_req(1'b1, 2'd2, 1'b0, DATA_BEGIN + 32'h10, 32'hDEAD_BEEF);
        check("sw_lat",   t_lat, 32'd2);
        check("sw_err",   32'(t_err), 32'd0);
        check("sw_beats", wr_total - w0, 32'd1);
        check("sw_addr",  wlog_addr[w0], 32'h0000_1010);
        check("sw_be",    32'(wlog_be[w0]), 32'hF);
        check("sw_data",  wlog_dat[w0], 32'hDEAD_BEEF);
        check("sw_nord",  rd_cycles - r0, 32'd0);

        do_req(1'b0, 2'd2, 1'b0, DATA_BEGIN + 32'h10, 32'h0);
        check("lw_lat",   t_lat, 32'd3);
        check("lw_data",  t_rd, 32'hDEAD_BEEF);
        check("lw_rdcyc", rd_cycles - r0, 32'd2);
        check("lw_nowr",  wr_total - w0, 32'd0);

        // byte lane 3
        do_req(1'b1, 2'd0, 1'b0, DATA_BEGIN + 32'h13, 32'h0000_0080);
        check("sb_lat",  t_lat, 32'd2);
        check("sb_addr", wlog_addr[w0], 32'h0000_1010);
        check("sb_be",   32'(wlog_be[w0]), 32'h8);
        check("sb_data", wlog_dat[w0], 32'h8000_0000);

        do_req(1'b0, 2'd0, 1'b0, DATA_BEGIN + 32'h13, 32'h0);
        check("lb_signed", t_rd, 32'hFFFF_FF80);
        do_req(1'b0, 2'd0, 1'b1, DATA_BEGIN + 32'h13, 32'h0);
        check("lbu_data", t_rd, 32'h0000_0080);

        // non-crossing halfword at offset 1
        do_req(1'b1, 2'd1, 1'b0, DATA_BEGIN + 32'h21, 32'h0000_A5C3);
        check("sh_lat",   t_lat, 32'd2);
        check("sh_beats", wr_total - w0, 32'd1);
        check("sh_addr",  wlog_addr[w0], 32'h0000_1020);
        check("sh_be",    32'(wlog_be[w0]), 32'h6);
        check("sh_data",  wlog_dat[w0], 32'h00A5_C300);

        do_req(1'b0, 2'd1, 1'b0, DATA_BEGIN + 32'h21, 32'h0);
        check("lh_lat",  t_lat, 32'd3);
        check("lh_data", t_rd, 32'hFFFF_A5C3);

        // word crossing a word boundary
        do_req(1'b1, 2'd2, 1'b0, DATA_BEGIN + 32'h32, 32'h1122_3344);
`ifdef MISALIGNED_SPLIT_EN
        check("xsw_lat",   t_lat, 32'd3);
        check("xsw_err",   32'(t_err), 32'd0);
        check("xsw_beats", wr_total - w0, 32'd2);
        check("xsw_addr0", wlog_addr[w0], 32'h0000_1030);
        check("xsw_be0",   32'(wlog_be[w0]), 32'hC);
        check("xsw_data0", wlog_dat[w0], 32'h3344_0000);
        check("xsw_addr1", wlog_addr[w0+1], 32'h0000_1034);
        check("xsw_be1",   32'(wlog_be[w0+1]), 32'h3);
        check("xsw_data1", wlog_dat[w0+1], 32'h0000_1122);
`else
        check("xsw_lat",   t_lat, 32'd1);
        check("xsw_err",   32'(t_err), 32'd1);
        check("xsw_beats", wr_total - w0, 32'd0);
`endif

        do_req(1'b0, 2'd2, 1'b0, DATA_BEGIN + 32'h32, 32'h0);
`ifdef MISALIGNED_SPLIT_EN
        check("xlw_lat",   t_lat, 32'd5);
        check("xlw_err",   32'(t_err), 32'd0);
        check("xlw_data",  t_rd, 32'h1122_3344);
        check("xlw_rdcyc", rd_cycles - r0, 32'd4);
`else
        check("xlw_lat",   t_lat, 32'd1);
        check("xlw_err",   32'(t_err), 32'd1);
        check("xlw_data",  t_rd, 32'h0);
        check("xlw_rdcyc", rd_cycles - r0, 32'd0);
`endif

        // illegal size
        do_req(1'b0, 2'd3, 1'b0, DATA_BEGIN, 32'h0);
        check("ill_lat",   t_lat, 32'd1);
        check("ill_err",   32'(t_err), 32'd1);
        check("ill_data",  t_rd, 32'h0);
        check("ill_rdcyc", rd_cycles - r0, 32'd0);
        do_req(1'b1, 2'd3, 1'b0, DATA_BEGIN, 32'hFFFF_FFFF);
        check("ills_err",   32'(t_err), 32'd1);
        check("ills_beats", wr_total - w0, 32'd0);

        // reset while a load sits in CAPTURE
        @(negedge clock);
        rc = resp_count;
        lsu.req_write    = 1'b0;
        lsu.req_size     = 2'd2;
        lsu.req_unsigned = 1'b0;
        lsu.req_address  = DATA_BEGIN + 32'h10;
        lsu.req_valid    = 1'b1;
        @(posedge clock);
        #1 lsu.req_valid = 1'b0;
        @(posedge clock);
        #1;
        check("cap_re", 32'(lsu.bus_read_enable), 32'd1);
        reset_n = 1'b0;
        #1;
        check("mid_rvalid",  32'(lsu.resp_valid), 32'd0);
        check("mid_rerror",  32'(lsu.resp_error), 32'd0);
        check("mid_rdata",   lsu.resp_rdata, 32'd0);
        check("mid_baddr",   lsu.bus_address, 32'd0);
        check("mid_bwdata",  lsu.bus_write_data, 32'd0);
        check("mid_be",      32'(lsu.bus_byte_enable), 32'd0);
        check("mid_strobes", 32'({lsu.bus_read_enable, lsu.bus_write_enable}), 32'd0);
        check("mid_ready",   32'(lsu.req_ready), 32'd1);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (4) @(negedge clock);
        check("rst_no_resp", rc - resp_count, 32'd0);
        check("post_ready",  32'(lsu.req_ready), 32'd1);

        do_req(1'b0, 2'd2, 1'b0, DATA_BEGIN + 32'h10, 32'h0);
        check("post_lat",  t_lat, 32'd3);
        check("post_data", t_rd, 32'h80AD_BEEF);

        // halfword crossing the top of the address space
        do_req(1'b1, 2'd1, 1'b0, 32'hFFFF_FFFF, 32'h0000_BEEF);
`ifdef MISALIGNED_SPLIT_EN
        check("wrap_beats", wr_total - w0, 32'd2);
        check("wrap_addr0", wlog_addr[w0], 32'hFFFF_FFFC);
        check("wrap_be0",   32'(wlog_be[w0]), 32'h8);
        check("wrap_data0", wlog_dat[w0], 32'hEF00_0000);
        check("wrap_addr1", wlog_addr[w0+1], 32'h0000_0000);
        check("wrap_be1",   32'(wlog_be[w0+1]), 32'h1);
        check("wrap_data1", wlog_dat[w0+1], 32'h0000_00BE);
        do_req(1'b0, 2'd1, 1'b1, 32'hFFFF_FFFF, 32'h0);
        check("wrap_lat",  t_lat, 32'd5);
        check("wrap_data", t_rd, 32'h0000_BEEF);
`else
        check("wrap_lat",   t_lat, 32'd1);
        check("wrap_err",   32'(t_err), 32'd1);
        check("wrap_beats", wr_total - w0, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
